// File: rtl/lock_code_sender.sv
// lock_code_sender
//   Plays a 16-bit code into the lock as four nibbles, MSB nibble first.
//   Each nibble is presented on `switch` and then strobed with `enter`.
//   After the last digit the block watches `status` and reports the result
//   on `granted` or `timeout`.
//
//   Optional build macro LOCK_CODE_SENDER_PRE_CLEAR_EN adds a CLR phase after
//   start. In that phase `clear` is pulsed before the first digit is sent.
//   Without the macro, `clear` is tied low.
//
// Ports
//   clk        : system clock, rising edge
//   master_rst : asynchronous, active-high reset
//   start      : request transmission (sampled only in IDLE)
//   code       : code to send, latched when start is accepted
//   status     : lock status, synchronous to clk
//   switch     : digit presented to the lock
//   enter      : digit strobe to the lock
//   clear      : entry-clear strobe (pre-clear build only, else 0)
//   busy       : high from accepted start until done
//   done       : single-cycle completion pulse
//   granted    : lock opened; held until next accepted start
//   timeout    : lock did not open; held until next accepted start
//   digit_idx  : index of the digit currently being sent (0 = first)
module lock_code_sender #(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter logic [1:0]  OPEN_STATUS = 2'b01
) (
    input  logic        clk,
    input  logic        master_rst,
    input  logic        start,
    input  logic [15:0] code,
    input  logic [1:0]  status,
    output logic [3:0]  switch,
    output logic        enter,
    output logic        clear,
    output logic        busy,
    output logic        done,
    output logic        granted,
    output logic        timeout,
    output logic [1:0]  digit_idx
);

    localparam int unsigned CLR_CYC = PULSE_CYC + GAP_CYC;
    localparam int unsigned MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_B   = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
    localparam int unsigned MAX_C   = (MAX_B > TIMEOUT_CYC) ? MAX_B : TIMEOUT_CYC;
    localparam int unsigned MAX_D   = (MAX_C > CLR_CYC) ? MAX_C : CLR_CYC;
    // Counter only ever holds (phase length - 1).
    localparam int unsigned CNT_W   = (MAX_D > 1) ? $clog2(MAX_D) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef LOCK_CODE_SENDER_PRE_CLEAR_EN
        S_CLR,
`endif
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_WAIT
    } state_t;

    state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [15:0]  code_r, code_n;
    logic [1:0]   idx_n;
    logic [3:0]   switch_n;
    logic         enter_n, busy_n, done_n, granted_n, timeout_n;
`ifdef LOCK_CODE_SENDER_PRE_CLEAR_EN
    logic         clear_r, clear_n;
    assign clear = clear_r;
`else
    assign clear = 1'b0;
`endif

    function automatic logic [3:0] nibble(input logic [15:0] c, input logic [1:0] i);
        case (i)
            2'd0:    nibble = c[15:12];
            2'd1:    nibble = c[11:8];
            2'd2:    nibble = c[7:4];
            default: nibble = c[3:0];
        endcase
    endfunction

    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            code_r    <= '0;
            digit_idx <= '0;
            switch    <= '0;
            enter     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            granted   <= 1'b0;
            timeout   <= 1'b0;
`ifdef LOCK_CODE_SENDER_PRE_CLEAR_EN
            clear_r   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            code_r    <= code_n;
            digit_idx <= idx_n;
            switch    <= switch_n;
            enter     <= enter_n;
            busy      <= busy_n;
            done      <= done_n;
            granted   <= granted_n;
            timeout   <= timeout_n;
`ifdef LOCK_CODE_SENDER_PRE_CLEAR_EN
            clear_r   <= clear_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        code_n    = code_r;
        idx_n     = digit_idx;
        switch_n  = switch;
        enter_n   = enter;
        busy_n    = busy;
        done_n    = 1'b0;
        granted_n = granted;
        timeout_n = timeout;
`ifdef LOCK_CODE_SENDER_PRE_CLEAR_EN
        clear_n   = clear_r;
`endif
        case (state)
            S_IDLE: begin
                switch_n = '0;
                enter_n  = 1'b0;
`ifdef LOCK_CODE_SENDER_PRE_CLEAR_EN
                clear_n  = 1'b0;
`endif
                if (start) begin
                    code_n    = code;
                    granted_n = 1'b0;
                    timeout_n = 1'b0;
                    busy_n    = 1'b1;
                    idx_n     = '0;
`ifdef LOCK_CODE_SENDER_PRE_CLEAR_EN
                    state_n   = S_CLR;
                    cnt_n     = CNT_W'(CLR_CYC - 1);
                    clear_n   = 1'b1;
`else
                    state_n   = S_SETUP;
                    cnt_n     = CNT_W'(SETUP_CYC - 1);
                    switch_n  = code[15:12];
`endif
                end
            end
`ifdef LOCK_CODE_SENDER_PRE_CLEAR_EN
            // One counter spans both halves: clear stays high while more
            // than GAP_CYC cycles remain, then the low gap follows.
            S_CLR: begin
                if (cnt == '0) begin
                    state_n  = S_SETUP;
                    cnt_n    = CNT_W'(SETUP_CYC - 1);
                    clear_n  = 1'b0;
                    switch_n = nibble(code_r, digit_idx);
                end else begin
                    cnt_n   = cnt - 1'b1;
                    clear_n = (cnt > CNT_W'(GAP_CYC));
                end
            end
`endif
            S_SETUP: begin
                if (cnt == '0) begin
                    state_n = S_PULSE;
                    cnt_n   = CNT_W'(PULSE_CYC - 1);
                    enter_n = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_n = S_GAP;
                    cnt_n   = CNT_W'(GAP_CYC - 1);
                    enter_n = 1'b0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    if (digit_idx == 2'd3) begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_W'(TIMEOUT_CYC - 1);
                    end else begin
                        state_n  = S_SETUP;
                        cnt_n    = CNT_W'(SETUP_CYC - 1);
                        idx_n    = digit_idx + 2'd1;
                        switch_n = nibble(code_r, digit_idx + 2'd1);
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            // A match is tested before the expiry check, so a match on the
            // final cycle still reports granted.
            S_WAIT: begin
                if (status == OPEN_STATUS) begin
                    state_n   = S_IDLE;
                    granted_n = 1'b1;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    switch_n  = '0;
                end else if (cnt == '0) begin
                    state_n   = S_IDLE;
                    timeout_n = 1'b1;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    switch_n  = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
